addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Shares one 24-bit adder/subtractor datapath between `NREQ` requesters. Requesters present operand pairs and an add/subtract opcode over valid/ready handshakes; the block grants them round-robin and computes one operation per cycle. It returns each result through a single registered response channel tagged with the requester ID. It sits between the FPU mantissa/exponent control logic and the shared integer adder/subtractor.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `DW`, default 24: operand/result width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NREQ: per-requester request valid.
- `req_ready` output NREQ: per-requester accept; one-hot or zero.
- `req_a` input NREQ×DW: operand A per requester.
- `req_b` input NREQ×DW: operand B per requester.
- `req_op` input NREQ: 0 = A+B, 1 = A−B.
- `rsp_valid` output 1: response register holds a result.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output $clog2(NREQ): index of the requester that issued the result.
- `rsp_result` output DW: sum/difference modulo 2^DW.
- `rsp_cout` output 1: carry (add) or no-borrow (sub).
- `op_count` output 16: count of completed response transfers; wraps.

## Operation
- Transfer on requester *i* when `req_valid[i] && req_ready[i]`. The response transfers when `rsp_valid && rsp_ready`.
- Requesters hold `req_a`, `req_b`, `req_op` and `req_valid` stable until accepted. `req_valid` never depends on `req_ready`.
- `can_accept = !rsp_valid || rsp_ready`, so the block accepts one request per cycle with back-to-back throughput.
- Round-robin grant:
  - Priority search starts at `last_grant+1` mod NREQ.
  - The first requester with `req_valid` set wins.
  - `req_ready` = grant one-hot ANDed with `can_accept`.
  - `last_grant` updates only on an actual transfer.
  - An idle cycle does not move the pointer.
- Arithmetic, computed on the granted operands:
  - Add: `{rsp_cout, rsp_result} = A + B`, 25-bit.
  - Sub: `rsp_result = (A − B) mod 2^DW` via A + ~B + 1. `rsp_cout = 1` iff A ≥ B unsigned.
- Output register (2-state: EMPTY / FULL, i.e. `rsp_valid`):
  - EMPTY, accept → FULL.
  - FULL, drain with no accept → EMPTY.
  - FULL, drain and accept in the same cycle → FULL, with the new data.
  - FULL, no drain → hold all `rsp_*` stable and drive `req_ready = 0`.
- `op_count` increments on each response transfer and wraps 0xFFFF→0.

## Timing
- Latency: request accepted at edge *n* → `rsp_valid` and data visible after edge *n*, i.e. 1 cycle.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `last_grant`. All `rsp_*` outputs and `op_count` are registered.
- Reset values:
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_result = 0`, `rsp_cout = 0`, `op_count = 0`.
  - `last_grant = NREQ−1`, so requester 0 has first priority.
  - `req_ready = 0` while `rst` is high.
- Reset mid-operation: a pending response is discarded, the counter clears, and no transfer is reported in the reset cycle.
- Simultaneous requests from all requesters: the grant rotates and each is served within NREQ accepts.
- Single requester streaming: served every cycle while `rsp_ready = 1`.

## Structure
- Package `addsub_arb_pkg`:
  - `DW_DEFAULT = 24`.
  - `typedef enum logic {OP_ADD, OP_SUB} addsub_op_e`.
  - Response struct: id, result, cout.
- Sub-module `rr_arbiter`, parameterised NREQ:
  - Inputs: request vector, `advance` strobe.
  - Outputs: one-hot grant and grant index.
  - Holds `last_grant`.
- The adder/subtractor datapath is the team's existing 24-bit combinational adder/subtractor, instantiated once. Top-level muxing, the output register and the counter sit in `addsub_arbiter`.

## Test plan
- Add with carry: req0 A=0x651652, B=0xC877CF, op=0, `rsp_ready=1` → next cycle `rsp_valid=1`, `rsp_id=0`, `rsp_result=0x2D8E21`, `rsp_cout=1`.
- Subtract with borrow: req1 A=5, B=10, op=1 → `rsp_result=0xFFFFFB`, `rsp_cout=0`, `rsp_id=1`. Then A=30, B=10, op=1 → 0x000014, `rsp_cout=1`.
- Contention: both requesters valid continuously after reset, `rsp_ready=1` → `rsp_id` sequence 0,1,0,1…; one response per cycle; `op_count` = number of cycles.
- Backpressure: `rsp_ready=0` for 3 cycles with the response FULL → `rsp_*` stable, `req_ready=0`. Release → drains, and the next grant is accepted in the same cycle.
- Reset mid-operation: assert `rst` asynchronously while FULL → `rsp_valid`, `op_count`, `req_ready` drop to 0 immediately. After release, requester 0 wins first.
- Counter wrap: 65536 transfers → `op_count` returns to 0.

Source files
------------

// File: rtl/addsub_arb_pkg.sv
// addsub_arb_pkg: shared types and constants for the arbitrated adder/subtractor
// Contents: default width, opcode enum, response-register state, response record.
package addsub_arb_pkg;
  localparam int DW_DEFAULT = 24;
  typedef enum logic {OP_ADD, OP_SUB} addsub_op_e;
  typedef enum logic {EMPTY, FULL} rsp_state_e;
  typedef struct packed {
    logic [2:0]            id;
    logic [DW_DEFAULT-1:0] result;
    logic                  cout;
  } addsub_rsp_t;
endpackage

// File: rtl/addsub_unit.sv
// addsub_unit: combinational DW-bit adder/subtractor
// Ports: a, b operands; op add/sub; result modulo 2^DW; cout carry (add) or no-borrow (sub).
module addsub_unit
  import addsub_arb_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  addsub_op_e    op,
  output logic [DW-1:0] result,
  output logic          cout
);
  logic          sub;
  logic [DW-1:0] b_eff;
  logic [DW:0]   sum;
  assign sub   = op == OP_SUB;
  assign b_eff = sub ? ~b : b;
  // subtraction is a + ~b + 1, so the carry out means a >= b
  assign sum   = {1'b0, a} + {1'b0, b_eff} + (DW+1)'(sub);
  assign {cout, result} = sum;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a pointer that moves only on advance
// Ports: clk, rst (async); req vector; advance strobe; grant one-hot; grant_idx index.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);
  logic [IW-1:0] last_grant;
  logic          found;
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(last_grant) + k) % NREQ;
      if (!found && req[j[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = j[IW-1:0];
      end
    end
  end
  assign grant = found ? (NREQ'(1) << grant_idx) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= IW'(NREQ - 1);
    else if (advance) last_grant <= grant_idx;
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin shared adder/subtractor with a registered tagged response
// Ports: clk, rst (async); req_valid/req_ready/req_a/req_b/req_op per requester;
//        rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_cout response; op_count response transfers.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW = DW_DEFAULT,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][DW-1:0]  req_a,
  input  logic [NREQ-1:0][DW-1:0]  req_b,
  input  logic [NREQ-1:0]          req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [DW-1:0]            rsp_result,
  output logic                     rsp_cout,
  output logic [15:0]              op_count
);
  rsp_state_e    state, state_nxt;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] grant_idx;
  logic          can_accept, advance, cout;
  logic [DW-1:0] result;
  assign can_accept = !rsp_valid || rsp_ready;
  // rst gate keeps req_ready low during reset, when the empty register would otherwise accept
  assign req_ready  = (!rst && can_accept) ? grant : '0;
  assign advance    = |req_ready;
  assign rsp_valid  = state == FULL;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );
  addsub_unit #(.DW(DW)) u_alu (
    .a      (req_a[grant_idx]),
    .b      (req_b[grant_idx]),
    .op     (addsub_op_e'(req_op[grant_idx])),
    .result (result),
    .cout   (cout)
  );
  always_comb begin
    state_nxt = state;
    if (advance) state_nxt = FULL;
    else if (rsp_ready) state_nxt = EMPTY;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      op_count   <= '0;
    end else begin
      if (advance) begin
        rsp_id     <= grant_idx;
        rsp_result <= result;
        rsp_cout   <= cout;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed vectors with hand-computed results for addsub_arbiter
module tb_addsub_arbiter;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = 2'b11;
  logic [1:0]      req_ready;
  logic [1:0][23:0] req_a = '0;
  logic [1:0][23:0] req_b = '0;
  logic [1:0]      req_op = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic            rsp_id;
  logic [23:0]     rsp_result;
  logic            rsp_cout;
  logic [15:0]     op_count;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  addsub_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .op_count   (op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = 2'b00;
    rst = 1'b0;
    step();
    // add with carry on requester 0
    req_valid = 2'b01;
    req_a[0] = 24'h651652; req_b[0] = 24'hC877CF; req_op[0] = 1'b0;
    #1 check("add_ready", 32'(req_ready), 32'h1);
    step();
    check("add_valid", 32'(rsp_valid), 32'd1);
    check("add_id", 32'(rsp_id), 32'd0);
    check("add_result", 32'(rsp_result), 32'h2D8E21);
    check("add_cout", 32'(rsp_cout), 32'd1);
    check("add_count", 32'(op_count), 32'd0);
    // subtract with borrow, then without, on requester 1
    req_valid = 2'b10;
    req_a[1] = 24'd5; req_b[1] = 24'd10; req_op[1] = 1'b1;
    step();
    check("sub_b_id", 32'(rsp_id), 32'd1);
    check("sub_b_result", 32'(rsp_result), 32'hFFFFFB);
    check("sub_b_cout", 32'(rsp_cout), 32'd0);
    check("sub_b_count", 32'(op_count), 32'd1);
    req_a[1] = 24'd30;
    step();
    check("sub_result", 32'(rsp_result), 32'h000014);
    check("sub_cout", 32'(rsp_cout), 32'd1);
    req_valid = 2'b00;
    step();
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check("idle_count", 32'(op_count), 32'd3);
    // contention: both requesters continuously valid
    req_a[0] = 24'h000100; req_b[0] = 24'h000023; req_op[0] = 1'b0;
    req_a[1] = 24'h000001; req_b[1] = 24'h000002; req_op[1] = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_id", 32'(rsp_id), 32'(i % 2));
      check("rr_result", 32'(rsp_result), (i % 2) ? 32'hFFFFFF : 32'h000123);
    end
    check("rr_count", 32'(op_count), 32'd8);
    // backpressure: response held, no request accepted
    rsp_ready = 1'b0;
    #1 check("bp_ready0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_result", 32'(rsp_result), 32'hFFFFFF);
      check("bp_cout", 32'(rsp_cout), 32'd0);
      check("bp_count", 32'(op_count), 32'd8);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 check("rel_ready", 32'(req_ready), 32'h1);
    step();
    check("rel_id", 32'(rsp_id), 32'd0);
    check("rel_result", 32'(rsp_result), 32'h000123);
    check("rel_count", 32'(op_count), 32'd9);
    // asynchronous reset while a response is held; pointer now favours requester 1
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_count", 32'(op_count), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    check("post_rst_id", 32'(rsp_id), 32'd0);
    check("post_rst_count", 32'(op_count), 32'd0);
    // single requester streaming until op_count wraps
    req_valid = 2'b01;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    check("stream_ready", 32'(req_ready), 32'h1);
    check("wrap_ffff", 32'(op_count), 32'hFFFF);
    step();
    check("wrap_zero", 32'(op_count), 32'd0);
    check("wrap_valid", 32'(rsp_valid), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
